serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller. One shared 1-bit full_adder (a, b, cin -> sum, carry) adds two WIDTH-bit operands, LSB first, one bit per clock.
- A carry flip-flop feeds the carry between cycles.
- Operand capture, bit sequencing and result hand-off to downstream logic use a start/busy/done handshake.
- Sits between the operand source and result consumer where area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request an add; sampled only when idle or done
- a  in  WIDTH  operand A, captured on accepted start
- b  in  WIDTH  operand B, captured on accepted start
- cin  in  1  initial carry-in, captured on accepted start
- busy  out  1  high while bits are being processed
- done  out  1  one-cycle pulse: result valid
- sum  out  WIDTH  registered result
- carry  out  1  registered final carry-out

Behaviour:
- Reset: rst is sampled at the rising edge of clk and overrides everything else.
  - State goes to IDLE.
  - busy=0, done=0, sum=0, carry=0.
  - Internal operand shift registers, bit counter and carry flip-flop are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: capture a, b and cin into internal registers, clear the bit counter, go to RUN.
  - start=0: stay in IDLE.
- RUN: one bit per edge.
  - full_adder inputs: a_reg[0], b_reg[0], carry_ff.
  - At each edge, shift the fa sum bit into the MSB end of the partial-result register.
  - Shift a_reg and b_reg right by 1.
  - carry_ff <= fa carry.
  - Increment the counter.
  - On the edge that processes bit WIDTH-1:
    - copy the partial result to sum and carry_ff' to carry;
    - go to DONE.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0.
  - Next edge with start=1: accept new operands, go to RUN (back-to-back, no idle gap).
  - Next edge with start=0: go to IDLE.
- Latency:
  - Start is accepted at edge E.
  - busy=1 after E through the cycle before E+WIDTH.
  - done=1 in the cycle after edge E+WIDTH.
  - Throughput: one add per WIDTH+1 cycles back-to-back.
- busy = (state==RUN). done = (state==DONE).
- sum and carry change only on the completing edge (or on reset).
  - They hold their last value through IDLE and through the next RUN.
  - They never show partial results.
- start in RUN is ignored. a, b and cin changing during RUN have no effect.
- Arithmetic: {carry,sum} = a + b + cin, modulo 2^(WIDTH+1); unsigned.
  - Wrap: all-ones + 1 gives sum=0, carry=1.
- Reset mid-RUN: the operation is aborted, no done pulse is produced, and outputs go to the reset values above.
- rst and start both high at the same edge: rst wins, start is dropped.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit): signed two's-complement overflow = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
  - Registered on the completing edge alongside sum; reset 0; held like sum.
  - Needs one extra flop that captures the carry_ff value in use while bit WIDTH-1 is processed.
- Not defined: no ovf port, no extra logic. All other behaviour is identical.

Test Plan (WIDTH=8):
1. Reset, then start with a=0x00, b=0x00, cin=0 -> busy high 8 cycles, then done=1 for exactly one cycle with sum=0x00, carry=0; done appears 8 edges after the accepting edge.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, carry=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, carry=1.
3. a=0x7F, b=0x01, cin=0 -> sum=0x80, carry=0; with SERIAL_ADD_OVF_EN, ovf=1. a=0x80, b=0x80 -> sum=0x00, carry=1, ovf=1.
4. a=0x35, b=0x4A, cin=1, accepted. In RUN cycle 3: start=1 with a=0x01, b=0x01. Expected: ignored; sum=0x80, carry=0; only one done pulse.
5. Start with a=0x12, b=0x34. Assert rst in RUN cycle 4. Expected: busy=0, done never pulses, sum=0x00, carry=0. Then a new start with a=0x12, b=0x34 gives sum=0x46.
6. Back-to-back: hold start=1 during the done cycle with a=0x10, b=0x20. Expected: first result reported, busy rises the next cycle, second done shows sum=0x30 exactly 9 cycles after the first done.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder, LSB first; done WIDTH+1 cycles after start, start ignored while busy.
// Optional SERIAL_ADD_OVF_EN adds a registered signed-overflow output (ovf).

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg, part;
  logic [CW-1:0]    cnt;
  logic             carry_ff;
  logic             fa_sum, fa_carry;
  logic             accept, last_bit;

  full_adder u_fa (
    .a     (a_reg[0]),
    .b     (b_reg[0]),
    .cin   (carry_ff),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Result outputs update only on the completing edge, so partial sums never leak out.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      part     <= '0;
      cnt      <= '0;
      carry_ff <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf      <= 1'b0;
`endif
    end else if (accept) begin
      a_reg    <= a;
      b_reg    <= b;
      carry_ff <= cin;
      cnt      <= '0;
      part     <= '0;
    end else if (state == RUN) begin
      a_reg    <= a_reg >> 1;
      b_reg    <= b_reg >> 1;
      part     <= {fa_sum, part[WIDTH-1:1]};
      carry_ff <= fa_carry;
      cnt      <= cnt + 1'b1;
      if (last_bit) begin
        sum   <= {fa_sum, part[WIDTH-1:1]};
        carry <= fa_carry;
`ifdef SERIAL_ADD_OVF_EN
        // carry_ff here is the carry into the sign bit.
        ovf   <= carry_ff ^ fa_carry;
`endif
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized bench for serial_adder_ctrl against an arithmetic reference model.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, carry;
  logic [W-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_done_cyc = 0;

  logic [W-1:0] h_sum = '0;
  logic         h_carry = 1'b0;
  logic         h_ovf = 1'b0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One add; inject>0 raises start with junk operands during that RUN cycle.
  task automatic run_add(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic cv, input int inject, input string tag);
    logic [W:0] full;
    logic       exp_ovf;
    full    = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    exp_ovf = (av[W-1] == bv[W-1]) && (full[W-1] != av[W-1]);
    a = av; b = bv; cin = cv; start = 1'b1;
    tick;
    for (int k = 1; k <= W; k++) begin
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL %s run_flags cyc%0d: busy=%b done=%b, required busy=1 done=0", tag, k, busy, done);
      end
      n_cmp++;
      if (sum !== h_sum || carry !== h_carry) begin
        n_bad++;
        $display("FAIL %s held_result cyc%0d: sum=%h carry=%b, required sum=%h carry=%b",
                 tag, k, sum, carry, h_sum, h_carry);
      end
      if (k == inject) begin
        start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
      end else begin
        start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
      tick;
    end
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s done_flags: busy=%b done=%b, required busy=0 done=1", tag, busy, done);
    end
    n_cmp++;
    if (sum !== full[W-1:0] || carry !== full[W]) begin
      n_bad++;
      $display("FAIL %s result: sum=%h carry=%b, required sum=%h carry=%b",
               tag, sum, carry, full[W-1:0], full[W]);
    end
`ifdef SERIAL_ADD_OVF_EN
    n_cmp++;
    if (ovf !== exp_ovf) begin
      n_bad++;
      $display("FAIL %s ovf: got %b, required %b", tag, ovf, exp_ovf);
    end
`endif
    last_done_cyc = cyc;
    h_sum   = full[W-1:0];
    h_carry = full[W];
    h_ovf   = exp_ovf;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      tick;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== h_sum || carry !== h_carry) begin
        n_bad++;
        $display("FAIL %s idle: busy=%b done=%b sum=%h carry=%b, required busy=0 done=0 sum=%h carry=%b",
                 tag, busy, done, sum, carry, h_sum, h_carry);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0;
    tick; tick;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || carry !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b done=%b sum=%h carry=%b, required all 0", busy, done, sum, carry);
    end
`ifdef SERIAL_ADD_OVF_EN
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ovf: got %b, required 0", ovf);
    end
`endif
    // rst and start together: start must be dropped.
    start = 1'b1; a = 8'h11; b = 8'h22;
    tick;
    rst = 1'b0; start = 1'b0;
    tick;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_beats_start: busy=%b done=%b, required busy=0 done=0", busy, done);
    end
    h_sum = '0; h_carry = 1'b0; h_ovf = 1'b0;
  endtask

  task automatic test_basic;
    run_add(8'h00, 8'h00, 1'b0, 0, "zero");
    idle_cycles(1, "zero");
    run_add(8'hFF, 8'h01, 1'b0, 0, "wrap1");
    idle_cycles(1, "wrap1");
    run_add(8'hFF, 8'hFF, 1'b1, 0, "wrap2");
    idle_cycles(2, "wrap2");
  endtask

  task automatic test_ovf;
    run_add(8'h7F, 8'h01, 1'b0, 0, "ovf_pos");
    idle_cycles(1, "ovf_pos");
    run_add(8'h80, 8'h80, 1'b0, 0, "ovf_neg");
    idle_cycles(1, "ovf_neg");
  endtask

  task automatic test_start_ignored;
    run_add(8'h35, 8'h4A, 1'b1, 3, "ignore_start");
    idle_cycles(3, "ignore_start");
  endtask

  task automatic test_reset_mid_run;
    int dones;
    dones = 0;
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_busy_before: busy=%b, required 1", busy);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || carry !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_state: busy=%b done=%b sum=%h carry=%b, required all 0", busy, done, sum, carry);
    end
    h_sum = '0; h_carry = 1'b0; h_ovf = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      tick;
      if (done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones != 0) begin
      n_bad++;
      $display("FAIL midrst_no_done: saw %0d done pulses, required 0", dones);
    end
    run_add(8'h12, 8'h34, 1'b0, 0, "after_rst");
    n_cmp++;
    if (sum !== 8'h46) begin
      n_bad++;
      $display("FAIL after_rst_sum: got %h, required 46", sum);
    end
    idle_cycles(1, "after_rst");
  endtask

  task automatic test_back_to_back;
    int d1;
    run_add(8'h5A, 8'h0F, 1'b0, 0, "b2b_first");
    d1 = last_done_cyc;
    run_add(8'h10, 8'h20, 1'b0, 0, "b2b_second");
    n_cmp++;
    if (last_done_cyc - d1 != W + 1) begin
      n_bad++;
      $display("FAIL b2b_spacing: got %0d cycles, required %0d", last_done_cyc - d1, W + 1);
    end
    n_cmp++;
    if (sum !== 8'h30) begin
      n_bad++;
      $display("FAIL b2b_sum: got %h, required 30", sum);
    end
    idle_cycles(1, "b2b");
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      run_add(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, W)), "random");
      idle_cycles(int'($urandom_range(0, 2)), "random");
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_ovf;
    test_start_ignored;
    test_reset_mid_run;
    test_back_to_back;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
